// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic arithmetic blocks.
//   stoch_decode_state_e : decoder FSM states
//   stoch_scale_sat      : scale a window ones-count to an output width,
//                          saturating a full window (ones == 2^window_log2)
//                          to all-ones so it fits in 'width' bits.
package stoch_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } stoch_decode_state_e;

  localparam int STOCH_MAX_LOG2 = 16;

  function automatic logic [15:0] stoch_scale_sat(input logic [16:0] ones,
                                                  input int window_log2,
                                                  input int width);
    logic [16:0] n;
    n = 17'(1) << window_log2;
    if (ones >= n) return 16'((17'(1) << width) - 17'(1));
    return 16'(ones >> (window_log2 - width));
  endfunction

endpackage

// File: rtl/stoch_out_reg.sv
// One-entry valid/ready holding register.
//   load/din  : new result (wins over a same-edge transfer)
//   ready     : consumer accepts value when valid
//   value     : held result, stable while valid and no load
//   valid     : value available
//   overflow  : sticky, set when a held unaccepted result is overwritten
module stoch_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic             overflow
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      value    <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      value <= din;
      valid <= 1'b1;
      // a same-edge accept drains the old result, so nothing is lost
      if (valid && !ready) overflow <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stoch_decode.sv
// Stochastic-to-binary decoder. Counts ones over 2^WINDOW_LOG2 qualified
// samples and emits the scaled estimate through a valid/ready register.
//   CLK, nRST        : clock, async active-low reset
//   start            : begin a window (IDLE only)
//   cont             : at window end, immediately start the next window
//   bit_in, bit_en   : bitstream and its sample qualifier
//   value, valid     : decoded estimate and its valid flag
//   ready            : consumer accept
//   busy             : window in progress
//   overflow         : sticky, an unaccepted result was overwritten
module stoch_decode
  import stoch_pkg::*;
#(
  parameter int WINDOW_LOG2 = 8,
  parameter int WIDTH       = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic             cont,
  input  logic             bit_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             overflow
);

  localparam int CW = WINDOW_LOG2 + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << WINDOW_LOG2) - 1);

  if (WINDOW_LOG2 < 1 || WINDOW_LOG2 > STOCH_MAX_LOG2 ||
      WIDTH < 1 || WIDTH > WINDOW_LOG2) begin : g_bad_params
    $error("stoch_decode: need 1<=WINDOW_LOG2<=16 and 1<=WIDTH<=WINDOW_LOG2");
  end

  stoch_decode_state_e state, state_n;
  logic [CW-1:0]    ones, ones_n, samples, samples_n;
  logic [CW-1:0]    ones_final;
  logic [WIDTH-1:0] result;
  logic             load;

  // count including the current sample; only meaningful on the last one
  assign ones_final = ones + CW'(bit_in);
  assign result     = WIDTH'(stoch_scale_sat(17'(ones_final), WINDOW_LOG2, WIDTH));

  always_comb begin
    state_n   = state;
    ones_n    = ones;
    samples_n = samples;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n   = ACCUM;
          ones_n    = '0;
          samples_n = '0;
        end
      end
      ACCUM: begin
        if (bit_en) begin
          if (samples == LAST) begin
            // window end: counters restart so a continuous window has no gap
            load      = 1'b1;
            ones_n    = '0;
            samples_n = '0;
            state_n   = cont ? ACCUM : IDLE;
          end else begin
            ones_n    = ones_final;
            samples_n = samples + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      ones    <= '0;
      samples <= '0;
    end else begin
      state   <= state_n;
      ones    <= ones_n;
      samples <= samples_n;
    end
  end

  assign busy = (state == ACCUM);

  stoch_out_reg #(.WIDTH(WIDTH)) u_out (
    .CLK      (CLK),
    .nRST     (nRST),
    .load     (load),
    .din      (result),
    .ready    (ready),
    .value    (value),
    .valid    (valid),
    .overflow (overflow)
  );

endmodule

// File: doc/stoch_decode.md
# stoch_decode

Stochastic-to-binary decoder that sits directly downstream of `stoch_add` and the other stochastic arithmetic stages. It counts the ones in a unipolar bitstream over a fixed window of 2^WINDOW_LOG2 qualified samples and emits the scaled binary estimate through a valid/ready output register. It supports single-shot and continuous back-to-back windows, with no lost samples between windows in continuous mode.

## Interface
- `WINDOW_LOG2`, 8, log2 of window length N; legal range 1..16.
- `WIDTH`, 8, output value width; must satisfy WIDTH <= WINDOW_LOG2. Elaboration error otherwise.
- `CLK` input 1: single clock, rising edge.
- `nRST` input 1: reset, asynchronous, active-low.
- `start` input 1: begin a window. Accepted only in IDLE.
- `cont` input 1: continuous mode. Sampled at each window end.
- `bit_in` input 1: stochastic bitstream, e.g. `y` of `stoch_add`.
- `bit_en` input 1: sample qualifier. A sample counts only when this is high.
- `value` output WIDTH: decoded estimate, held while `valid` is high.
- `valid` output 1: `value` is available.
- `ready` input 1: consumer accepts `value`.
- `busy` output 1: high in ACCUM.
- `overflow` output 1: sticky flag, set when an unaccepted result is overwritten.

## Operation
- States:
  - IDLE: no window in progress.
  - ACCUM: counting.
- Counters:
  - `ones` is WINDOW_LOG2+1 bits, so it holds N itself.
  - `samples` is WINDOW_LOG2+1 bits.
- IDLE -> ACCUM on `start` high at an edge. On that edge `ones` and `samples` clear. The start edge itself does not sample `bit_in`.
- In ACCUM, each edge with `bit_en` high:
  - `samples` increments.
  - `ones` increments by `bit_in`.
- An edge with `bit_en` low changes neither counter.
- Window end is the edge taking the Nth qualified sample, counting that sample's bit. On that edge:
  - The result register loads `ones_final >> (WINDOW_LOG2-WIDTH)`.
  - If `ones_final == N`, the value saturates to all-ones (2^WIDTH-1).
  - `valid` sets.
  - If `cont` is high, stay in ACCUM with both counters cleared. The next edge is a sample edge, so there is no gap.
  - If `cont` is low, go to IDLE.
- `start` in ACCUM is ignored.
- Output handshake:
  - A transfer occurs on an edge with `valid && ready`. `valid` clears unless a new result loads on the same edge.
  - New result and transfer on the same edge: the new result loads, `valid` stays 1, and `overflow` is not set.
  - New result while `valid` is high and `ready` is low: `value` is overwritten and `overflow` sets.
  - `overflow` clears only on reset.
- `value` is stable while `valid` is high and no new result loads.

## Timing
- Reset values: state IDLE, counters 0, `value` 0, `valid` 0, `busy` 0, `overflow` 0.
- Reset is asynchronous and effective immediately, including mid-window. The partial window is discarded.
- Latency with `bit_en` held high: `start` accepted at edge 0, samples taken at edges 1..N, `valid` high after edge N.
- Each low `bit_en` cycle adds one cycle of latency.
- `busy` is registered: high the cycle after the start edge, low the cycle after the final edge of a non-continuous window.
- `value`, `valid` and `busy` are driven from registers. There are no combinational input-to-output paths.
- `ready` has no effect while `valid` is low.

## Structure
- Shared package `stoch_pkg`:
  - `stoch_decode_state_e` enum {IDLE, ACCUM}.
  - Helper function `stoch_scale_sat(ones, WINDOW_LOG2, WIDTH)`, reused by other stochastic-to-binary blocks.
- One sub-module is natural: `stoch_out_reg`, a one-entry valid/ready holding register with an overwrite/overflow flag.
- Counters and the FSM remain in `stoch_decode`.

## Test plan
- All-ones: N=256, WIDTH=8, `bit_in`=1, `bit_en`=1, `start` pulse -> `valid` after edge 256, `value`=255 (saturated), `overflow`=0.
- Alternating pattern: `bit_in` toggles 1,0,... with `bit_en`=1 -> `value`=128. With `bit_in`=0 throughout -> `value`=0.
- Gapped qualifier: `bit_en` high every other cycle, `bit_in`=1 -> `valid` after edge 512, `value`=255.
- Continuous with back-pressure: `cont`=1, `ready`=0, two windows of 64 ones and 192 ones:
  - `value` 64 after window 1, then 192 after window 2.
  - `overflow`=1 after window 2.
  - `samples` shows no gap between windows.
- Continuous with simultaneous accept: `ready` pulses on the edge window 2 ends -> `valid` stays 1, `value` = new result, `overflow`=0.
- Mid-window reset: `nRST` low asynchronously at sample 100 -> all outputs 0 immediately. A new `start` after release decodes a full fresh window.
